// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and defaults for the parametrised UART receiver.
//   rx_state_t          receiver FSM state encoding
//   DEF_*               default parameter values for uart_rx_param
//   MAX_DATA_BITS       widest supported data field
//   parity_bad()        1 when data plus parity bit disagree with the selected parity
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2,
    DONE
  } rx_state_t;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DIV_W      = 12;
  localparam int MAX_DATA_BITS  = 9;

  // Even parity: data plus parity bit hold an even number of ones (XOR = 0).
  // Odd parity: the XOR is 1. Unused upper data bits must be zero.
  function automatic logic parity_bad(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic par_bit,
                                      input logic odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: valid/ready output bus of the UART receiver.
//   data_out    received word
//   valid_out   word and status flags are valid
//   ready_in    consumer accepts the word when valid_out & ready_in
//   parity_err  parity mismatch for the held word
//   frame_err   a stop bit was sampled low for the held word
//   overrun     at least one frame was lost while the word was held
// master = receiver side, slave = consumer side.
interface uart_rx_param_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_out, valid_out, parity_err, frame_err, overrun,
    input  ready_in
  );

  modport slave (
    input  data_out, valid_out, parity_err, frame_err, overrun,
    output ready_in
  );
endinterface

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen: baud tick generator, shareable with the transmit path.
//   clk, reset  system clock, asynchronous active-high reset
//   en          counter runs while 1, held at 0 while 0
//   divisor     one tick every divisor+1 clocks (0 = tick every clock)
//   tick        1-cycle pulse on counter wrap
module uart_rx_tick_gen #(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a divisor lowered mid-count wraps at once
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q >= divisor) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with valid/ready output register.
//   clk, reset     system clock, asynchronous active-high reset
//   rx             serial input (asynchronous, idles high)
//   rx_en          receiver enable; dropping it mid-frame aborts the frame
//   parity_en      parity bit follows the data bits
//   parity_odd     1 = odd parity, 0 = even
//   stop2          two stop bits expected
//   baud_divisor   one oversample tick every baud_divisor+1 clocks
//   bus            uart_rx_param_if master: data_out/valid_out/ready_in + flags
// Build option UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of the
// samples at tc = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 (decided at
// OVERSAMPLE/2+1). Without it, a single sample at OVERSAMPLE/2.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | checking the start bit mid-bit (high = false start)
// DATA   | shifting in DATA_BITS bits, LSB first
// PARITY | checking the parity bit against the data
// STOP   | first stop bit, low sets frame error
// STOP2  | second stop bit, same check
// DONE   | one cycle, frame handed to the output register
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DIV_W      = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             rx_en,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic [DIV_W-1:0] baud_divisor,
  uart_rx_param_if.master  bus
);

  localparam int TC_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS);
  localparam logic [TC_W-1:0] TC_LAST  = TC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TC_W-1:0] TC_PRE  = TC_W'(OVERSAMPLE/2 - 1);
  localparam logic [TC_W-1:0] TC_MID  = TC_W'(OVERSAMPLE/2);
  localparam logic [TC_W-1:0] TC_POST = TC_W'(OVERSAMPLE/2 + 1);
`else
  localparam logic [TC_W-1:0] TC_MID  = TC_W'(OVERSAMPLE/2);
`endif

  // Synchroniser and edge register; preset high so reset is not a start edge.
  logic rx_meta_q, rx_s_q, rx_prev_q;

  logic tick;

  rx_state_t            state_q, state_d;
  logic [TC_W-1:0]      tc_q, tc_d;
  logic [BC_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 stop2_q, stop2_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_MAJORITY_EN
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
`endif

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;

  logic bit_evt;
  logic bit_val;
  logic hs;

  uart_rx_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (rx_en),
    .divisor (baud_divisor),
    .tick    (tick)
  );

  assign hs = valid_q & bus.ready_in;

  always_comb begin
    state_d    = state_q;
    tc_d       = tc_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = ovr_q;

`ifdef UART_RX_MAJORITY_EN
    s0_d = s0_q;
    s1_d = s1_q;
    if (tick && tc_q == TC_PRE) s0_d = rx_s_q;
    if (tick && tc_q == TC_MID) s1_d = rx_s_q;
    bit_evt = tick && (tc_q == TC_POST);
    bit_val = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
`else
    bit_evt = tick && (tc_q == TC_MID);
    bit_val = rx_s_q;
`endif

    // tc free-runs through every bit of the frame; each bit is decided at
    // the same tc value, so bits are spaced OVERSAMPLE ticks apart.
    if (state_q != IDLE && tick)
      tc_d = (tc_q == TC_LAST) ? '0 : tc_q + TC_W'(1);

    case (state_q)
      IDLE: begin
        tc_d  = '0;
        bit_d = '0;
        if (rx_en && rx_prev_q && !rx_s_q) begin
          state_d   = START;
          par_en_d  = parity_en;
          par_odd_d = parity_odd;
          stop2_d   = stop2;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      START: begin
        if (bit_evt) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (bit_evt) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
          else                   bit_d   = bit_q + BC_W'(1);
        end
      end
      PARITY: begin
        if (bit_evt) begin
          perr_d  = parity_bad(MAX_DATA_BITS'(shift_q), bit_val, par_odd_q);
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_evt) begin
          if (!bit_val) ferr_d = 1'b1;
          state_d = stop2_q ? STOP2 : DONE;
        end
      end
      STOP2: begin
        if (bit_evt) begin
          if (!bit_val) ferr_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!rx_en) state_d = IDLE;

    // A handshake in the DONE cycle frees the register for the new frame.
    if (state_q == DONE) begin
      if (!valid_q || hs) begin
        data_d     = shift_q;
        valid_d    = 1'b1;
        perr_out_d = perr_q;
        ferr_out_d = ferr_q;
        ovr_d      = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (hs) begin
      data_d     = '0;
      valid_d    = 1'b0;
      perr_out_d = 1'b0;
      ferr_out_d = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      tc_q       <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
`endif
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      tc_q       <= tc_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_MAJORITY_EN
      s0_q       <= s0_d;
      s1_q       <= s1_d;
`endif
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.parity_err = perr_out_q;
  assign bus.frame_err  = ferr_out_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param.
// dut1: DATA_BITS=8, OVERSAMPLE=16, baud_divisor=0 (16 clocks/bit).
// dut2: DATA_BITS=5, OVERSAMPLE=16, baud_divisor=3 (64 clocks/bit).
// Stimulus pushes the expected word; a monitor pops and compares on each
// handshake.
module tb_uart_rx_param;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx1, rx2;
  logic        rx_en, parity_en, parity_odd, stop2;
  logic        ready1, ready2;
  logic [11:0] div1, div2;

  int checks   = 0;
  int failures = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t m1, m2;

  uart_rx_param_if #(.DATA_BITS(8)) bus1 ();
  uart_rx_param_if #(.DATA_BITS(5)) bus2 ();

  assign bus1.ready_in = ready1;
  assign bus2.ready_in = ready2;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(12)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .rx_en(rx_en),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .baud_divisor(div1), .bus(bus1.master)
  );

  uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(16), .DIV_W(12)) dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .rx_en(rx_en),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .baud_divisor(div2), .bus(bus2.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic [8:0] d,
                       input logic pe, input logic fe, input logic ov);
    chk({tag, " data"},       32'(d),  32'(e.data));
    chk({tag, " parity_err"}, 32'(pe), 32'(e.pe));
    chk({tag, " frame_err"},  32'(fe), 32'(e.fe));
    chk({tag, " overrun"},    32'(ov), 32'(e.ov));
  endtask

  always @(negedge clk) begin
    if (!reset && bus1.valid_out && bus1.ready_in) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1 unexpected word: got data 0x%0h, required no word", bus1.data_out);
      end else begin
        m1 = q1.pop_front();
        score("dut1", m1, 9'(bus1.data_out), bus1.parity_err, bus1.frame_err, bus1.overrun);
      end
    end
    if (!reset && bus2.valid_out && bus2.ready_in) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut2 unexpected word: got data 0x%0h, required no word", bus2.data_out);
      end else begin
        m2 = q2.pop_front();
        score("dut2", m2, 9'(bus2.data_out), bus2.parity_err, bus2.frame_err, bus2.overrun);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after cpb clocks.
  task automatic drive_bit(input int which, input logic v, input int cpb);
    if (which == 1) rx1 = v;
    else            rx2 = v;
    repeat (cpb) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par_bit,
                            input logic stop_a, input bit two_stop, input logic stop_b,
                            input int gap_bits);
    int cpb;
    cpb = (which == 1) ? 16 : 64;
    drive_bit(which, 1'b0, cpb);
    for (int i = 0; i < nbits; i++) drive_bit(which, data[i], cpb);
    if (has_par)  drive_bit(which, par_bit, cpb);
    drive_bit(which, stop_a, cpb);
    if (two_stop) drive_bit(which, stop_b, cpb);
    for (int g = 0; g < gap_bits; g++) drive_bit(which, 1'b1, cpb);
  endtask

  task automatic wait_valid(input int which, input int max_cyc, input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = (which == 1) ? bus1.valid_out : bus2.valid_out;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: valid_out not seen within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic chk_zero(input string tag, input int which);
    if (which == 1) begin
      chk({tag, " data"},       32'(bus1.data_out),   32'h0);
      chk({tag, " valid"},      32'(bus1.valid_out),  32'h0);
      chk({tag, " parity_err"}, 32'(bus1.parity_err), 32'h0);
      chk({tag, " frame_err"},  32'(bus1.frame_err),  32'h0);
      chk({tag, " overrun"},    32'(bus1.overrun),    32'h0);
    end else begin
      chk({tag, " data"},       32'(bus2.data_out),   32'h0);
      chk({tag, " valid"},      32'(bus2.valid_out),  32'h0);
      chk({tag, " parity_err"}, 32'(bus2.parity_err), 32'h0);
      chk({tag, " frame_err"},  32'(bus2.frame_err),  32'h0);
      chk({tag, " overrun"},    32'(bus2.overrun),    32'h0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1; rx1 = 1'b1; rx2 = 1'b1; rx_en = 1'b1;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    ready1 = 1'b1; ready2 = 1'b1; div1 = 12'd0; div2 = 12'd3;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset dut1", 1);
    chk_zero("reset dut2", 2);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // 8N1 0xA5, valid pulses one cycle with ready tied high
    q1.push_back('{9'h0A5, 1'b0, 1'b0, 1'b0});
    fork
      send_frame(1, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
      begin
        wait_valid(1, 200, "8N1 valid", seen);
        @(posedge clk);
        #1;
        chk("8N1 valid pulse width", 32'(bus1.valid_out), 32'h0);
      end
    join

    // 8E1 0x03, parity bit driven 1 (correct is 0)
    parity_en = 1'b1; parity_odd = 1'b0;
    q1.push_back('{9'h003, 1'b1, 1'b0, 1'b0});
    send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1);

    // 8O1 0x07, parity bit 0 is correct for odd
    parity_odd = 1'b1;
    q1.push_back('{9'h007, 1'b0, 1'b0, 1'b0});
    send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1);

    // 8N2 0x5A, second stop bit low
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b1;
    q1.push_back('{9'h05A, 1'b0, 1'b1, 1'b0});
    send_frame(1, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);

    // 8N1 0x80, only stop bit low
    stop2 = 1'b0;
    q1.push_back('{9'h080, 1'b0, 1'b1, 1'b0});
    send_frame(1, 9'h080, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);

    // false start: 4-clock glitch, then a good 0x11 frame
    rx1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx1 = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    q1.push_back('{9'h011, 1'b0, 1'b0, 1'b0});
    send_frame(1, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);

    // rx_en dropped mid-frame: 0x55 is lost, following 0x66 is received
    drive_bit(1, 1'b0, 16);
    drive_bit(1, 1'b1, 16);
    drive_bit(1, 1'b0, 16);
    drive_bit(1, 1'b1, 8);
    rx_en = 1'b0;
    drive_bit(1, 1'b1, 8);
    for (int i = 3; i < 8; i++) drive_bit(1, (i % 2 == 0) ? 1'b1 : 1'b0, 16);
    drive_bit(1, 1'b1, 32);
    rx_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    q1.push_back('{9'h066, 1'b0, 1'b0, 1'b0});
    send_frame(1, 9'h066, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);

    // overrun: two back-to-back frames while ready is low
    ready1 = 1'b0;
    q1.push_back('{9'h012, 1'b0, 1'b0, 1'b1});
    send_frame(1, 9'h012, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    send_frame(1, 9'h034, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2);
    chk("overrun valid held", 32'(bus1.valid_out), 32'h1);
    ready1 = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("after handshake", 1);

    // dut2: 5-bit data, divisor 3
    q2.push_back('{9'h01F, 1'b0, 1'b0, 1'b0});
    send_frame(2, 9'h01F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    ready2 = 1'b0;
    send_frame(2, 9'h00E, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    wait_valid(2, 20, "dut2 held valid", seen);
    chk("dut2 held data", 32'(bus2.data_out), 32'h0E);
    // start another frame, reset in the middle of it
    drive_bit(2, 1'b0, 64);
    drive_bit(2, 1'b1, 64);
    drive_bit(2, 1'b0, 32);
    reset = 1'b1;
    #1;
    chk_zero("mid-frame reset dut2", 2);
    rx2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    ready2 = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    chk("dut1 scoreboard drained", 32'(q1.size()), 32'h0);
    chk("dut2 scoreboard drained", 32'(q2.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
